// File: rtl/vit_encoder_scheduler.sv
// vit_encoder_scheduler
// Runs one activation tile through NUM_LAYERS passes of a single shared
// encoder block. The scheduler owns the activation buffer, issues one
// start pulse per layer, loops each layer's result back as the next
// layer's input and publishes the last layer's result on y_out.
// A per-layer watchdog raises a sticky error if the encoder stalls, and
// abort returns the sequencer to IDLE from any state.

module vit_encoder_scheduler #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          SEQ_LEN     = 16,
    parameter int          EMB_DIM     = 32,
    parameter int          NUM_LAYERS  = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd65535,
    localparam int         NUM_ELEM    = SEQ_LEN * EMB_DIM,
    localparam int         LIDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] x_in      [NUM_ELEM],
    output logic                  enc_start,
    input  logic                  enc_done,
    output logic [DATA_WIDTH-1:0] enc_x_in  [NUM_ELEM],
    input  logic [DATA_WIDTH-1:0] enc_out   [NUM_ELEM],
    output logic [LIDX_W-1:0]     layer_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] y_out     [NUM_ELEM]
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    // Activation buffer; it is what the encoder sees as its input.
    logic [DATA_WIDTH-1:0] act_buf [NUM_ELEM];

    // Per-layer cycle counter for the stall watchdog.
    logic [31:0] wdog;

    // Single-cycle control strobes from the sequencer to the datapath.
    logic load_x;      // capture the new input tile
    logic load_act;    // loop encoder result back into act_buf
    logic load_y;      // publish final layer result
    logic layer_clr;
    logic layer_inc;
    logic wdog_clr;
    logic wdog_inc;
    logic err_set;
    logic err_clr;

    logic last_layer;
    logic wdog_hit;

    assign last_layer = (layer_idx == LIDX_W'(NUM_LAYERS - 1));

    // A zero timeout disables the watchdog entirely.
    assign wdog_hit = (TIMEOUT_CYC != 32'd0) && (wdog == (TIMEOUT_CYC - 32'd1));

    // The encoder reads the registered buffer directly, so its input stays
    // stable from ISSUE until the enc_done cycle that replaces it.
    assign enc_x_in = act_buf;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, decoded outputs and datapath strobes.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        enc_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load_x    = 1'b0;
        load_act  = 1'b0;
        load_y    = 1'b0;
        layer_clr = 1'b0;
        layer_inc = 1'b0;
        wdog_clr  = 1'b0;
        wdog_inc  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;

        unique case (state)
            // IDLE and ERR accept a new run identically; a restart from
            // ERR also clears the sticky error.
            S_IDLE, S_ERR: begin
                if (start) begin
                    load_x    = 1'b1;
                    layer_clr = 1'b1;
                    err_clr   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                enc_start = 1'b1;
                busy      = 1'b1;
                wdog_clr  = 1'b1;
                state_nxt = S_WAIT;
            end

            // enc_done is checked before the watchdog so a result that
            // arrives on the final allowed cycle is still accepted.
            S_WAIT: begin
                busy     = 1'b1;
                wdog_inc = 1'b1;
                if (enc_done) begin
                    if (last_layer) begin
                        load_y    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        load_act  = 1'b1;
                        layer_inc = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (wdog_hit) begin
                    err_set   = 1'b1;
                    state_nxt = S_ERR;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                layer_clr = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort outranks everything: drop any pending load, keep y_out,
        // rewind the layer counter and clear the error flag.
        if (abort) begin
            state_nxt = S_IDLE;
            load_x    = 1'b0;
            load_act  = 1'b0;
            load_y    = 1'b0;
            layer_inc = 1'b0;
            wdog_clr  = 1'b0;
            wdog_inc  = 1'b0;
            err_set   = 1'b0;
            layer_clr = 1'b1;
            err_clr   = 1'b1;
        end
    end

    // Activation buffer: new tile on start, encoder result between layers.
    // NOTE: these arrays are architecturally visible (enc_x_in, y_out) and
    // must read as zero after reset, so they are built from resettable
    // flops rather than an unreset RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_buf <= '{default: '0};
        end else if (load_x) begin
            act_buf <= x_in;
        end else if (load_act) begin
            act_buf <= enc_out;
        end
    end

    // Final result register; held until the next successful completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out <= '{default: '0};
        end else if (load_y) begin
            y_out <= enc_out;
        end
    end

    // Layer counter, also the weight/LN-parameter bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx <= '0;
        end else if (layer_clr) begin
            layer_idx <= '0;
        end else if (layer_inc) begin
            layer_idx <= layer_idx + LIDX_W'(1);
        end
    end

    // Watchdog counter: restarted on every issue, counts WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (wdog_clr) begin
            wdog <= '0;
        end else if (wdog_inc) begin
            wdog <= wdog + 32'd1;
        end
    end

    // Sticky error flag: set on watchdog expiry, cleared by restart or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (err_clr) begin
            error <= 1'b0;
        end else if (err_set) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vit_encoder_scheduler.sv
// tb_vit_encoder_scheduler
// Directed bench for the encoder scheduler. Two instances: a four-layer
// scheduler with an 8-cycle watchdog, and a single-layer scheduler with a
// small tile and the watchdog disabled. Each has a stub encoder that adds
// one to every element after a programmable latency.

module tb_vit_encoder_scheduler;

    localparam int DW = 16;
    localparam int AN = 16 * 32;
    localparam int BN = 2 * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic abort;
    bit   sel;    // 0: drive/observe instance a, 1: instance b

    // Instance a: NUM_LAYERS=4, TIMEOUT_CYC=8
    logic          a_start, a_abort, a_enc_start, a_busy, a_done, a_error;
    logic          a_enc_done = 1'b0;
    logic [1:0]    a_layer;
    logic [DW-1:0] a_x_in     [AN];
    logic [DW-1:0] a_enc_x_in [AN];
    logic [DW-1:0] a_enc_out  [AN] = '{default: '0};
    logic [DW-1:0] a_y_out    [AN];

    // Instance b: NUM_LAYERS=1, watchdog off, 2x4 tile
    logic          b_start, b_abort, b_enc_start, b_busy, b_done, b_error;
    logic          b_enc_done = 1'b0;
    logic [0:0]    b_layer;
    logic [DW-1:0] b_x_in     [BN];
    logic [DW-1:0] b_enc_x_in [BN];
    logic [DW-1:0] b_enc_out  [BN] = '{default: '0};
    logic [DW-1:0] b_y_out    [BN];

    assign a_start = start & ~sel;
    assign a_abort = abort & ~sel;
    assign b_start = start & sel;
    assign b_abort = abort & sel;

    vit_encoder_scheduler #(
        .DATA_WIDTH (DW),
        .SEQ_LEN    (16),
        .EMB_DIM    (32),
        .NUM_LAYERS (4),
        .TIMEOUT_CYC(32'd8)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (a_start),
        .abort    (a_abort),
        .x_in     (a_x_in),
        .enc_start(a_enc_start),
        .enc_done (a_enc_done),
        .enc_x_in (a_enc_x_in),
        .enc_out  (a_enc_out),
        .layer_idx(a_layer),
        .busy     (a_busy),
        .done     (a_done),
        .error    (a_error),
        .y_out    (a_y_out)
    );

    vit_encoder_scheduler #(
        .DATA_WIDTH (DW),
        .SEQ_LEN    (2),
        .EMB_DIM    (4),
        .NUM_LAYERS (1),
        .TIMEOUT_CYC(32'd0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (b_start),
        .abort    (b_abort),
        .x_in     (b_x_in),
        .enc_start(b_enc_start),
        .enc_done (b_enc_done),
        .enc_x_in (b_enc_x_in),
        .enc_out  (b_enc_out),
        .layer_idx(b_layer),
        .busy     (b_busy),
        .done     (b_done),
        .error    (b_error),
        .y_out    (b_y_out)
    );

    // Stub encoders: enc_done goes high exactly lat cycles after the cycle
    // in which enc_start is seen, with enc_out = enc_x_in + 1 per element.
    int a_cnt = 0;
    int a_lat = 5;
    bit a_en  = 1'b1;
    int b_cnt = 0;
    int b_lat = 3;

    always @(negedge clk) begin
        a_enc_done = 1'b0;
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0 && a_en) begin
                a_enc_done = 1'b1;
                for (int i = 0; i < AN; i++) a_enc_out[i] = a_enc_x_in[i] + 16'd1;
            end
        end
        if (a_enc_start) a_cnt = a_lat;
    end

    always @(negedge clk) begin
        b_enc_done = 1'b0;
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_enc_done = 1'b1;
                for (int i = 0; i < BN; i++) b_enc_out[i] = b_enc_x_in[i] + 16'd1;
            end
        end
        if (b_enc_start) b_cnt = b_lat;
    end

    // Observation mux for the selected instance.
    logic obs_enc_start, obs_busy, obs_done, obs_error;
    int   obs_layer;
    always_comb begin
        obs_enc_start = sel ? b_enc_start : a_enc_start;
        obs_busy      = sel ? b_busy      : a_busy;
        obs_done      = sel ? b_done      : a_done;
        obs_error     = sel ? b_error     : a_error;
        obs_layer     = sel ? int'(b_layer) : int'(a_layer);
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-run trace, filled by run_watch. Cycle 0 is the cycle start is high.
    int            st_cyc[$];
    int            st_layer[$];
    int            done_at;
    int            done_cnt;
    int            err_at;
    bit            busy_h [128];
    bit            err_h  [128];
    int            layer_h[128];
    logic [DW-1:0] snap_y;

    task automatic run_watch(input bit do_start, input int budget, input int pulse1,
                             input int pulse2, input int abort_at, input int snap_cyc,
                             input bit stop_on_end);
        st_cyc.delete();
        st_layer.delete();
        done_at  = -1;
        done_cnt = 0;
        err_at   = -1;
        snap_y   = '0;
        for (int t = 0; t <= budget; t++) begin
            @(negedge clk);
            busy_h[t]  = obs_busy;
            err_h[t]   = obs_error;
            layer_h[t] = obs_layer;
            if (obs_enc_start) begin
                st_cyc.push_back(t);
                st_layer.push_back(obs_layer);
            end
            if (obs_done) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (t >= 1 && obs_error && err_at < 0) err_at = t;
            if (t == snap_cyc) snap_y = a_y_out[0];
            start = (do_start && t == 0) || (t == pulse1) || (t == pulse2);
            abort = (t == abort_at);
            if (stop_on_end && (done_at >= 0 || err_at >= 0)) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Expected issue cycles 1 + i*(lat+1), layer i, done at layers*(lat+1)+1.
    task automatic check_run(input string tag, input int lat, input int layers);
        check({tag, "_nstart"}, st_cyc.size(), layers);
        for (int i = 0; i < layers && i < st_cyc.size(); i++) begin
            check($sformatf("%s_st%0d_cyc", tag, i), st_cyc[i], 1 + i * (lat + 1));
            check($sformatf("%s_st%0d_layer", tag, i), st_layer[i], i);
        end
        check({tag, "_done_cyc"}, done_at, layers * (lat + 1) + 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    function automatic bit a_y_all(input logic [DW-1:0] v);
        for (int i = 0; i < AN; i++) if (a_y_out[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit a_x_all(input logic [DW-1:0] v);
        for (int i = 0; i < AN; i++) if (a_enc_x_in[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_a_x(input logic [DW-1:0] v);
        for (int i = 0; i < AN; i++) a_x_in[i] = v;
    endtask

    initial begin
        int busy_sum;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sel   = 1'b0;
        set_a_x(16'h0000);
        for (int i = 0; i < BN; i++) b_x_in[i] = 16'h0100 + 16'(i * 3);

        // Reset state
        #2;
        check("rst_enc_start", a_enc_start, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_error", a_error, 0);
        check("rst_layer", a_layer, 0);
        check("rst_y_zero", a_y_all(16'h0000), 1);
        check("rst_encx_zero", a_x_all(16'h0000), 1);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_y0", b_y_out[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Four layers, T=5, 0x0010 -> 0x0014 at cycle 25
        a_lat = 5;
        a_en  = 1'b1;
        set_a_x(16'h0010);
        run_watch(1'b1, 60, -1, -1, -1, -1, 1'b1);
        check_run("norm", 5, 4);
        check("norm_y", a_y_all(16'h0014), 1);
        check("norm_busy_in_done", a_busy, 0);
        check("norm_actbuf_last_in", a_x_all(16'h0013), 1);
        @(negedge clk);
        check("norm_layer_idle", a_layer, 0);
        check("norm_done_one_cycle", a_done, 0);

        // Stalled encoder: error after 8 WAIT cycles (WAIT 2..9, ERR at 10)
        a_en = 1'b0;
        set_a_x(16'h0100);
        run_watch(1'b1, 40, -1, -1, -1, -1, 1'b1);
        check("to_err_cyc", err_at, 10);
        check("to_busy_wait", busy_h[9], 1);
        check("to_busy_err", busy_h[10], 0);
        check("to_no_done", done_cnt, 0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", a_error, 1);

        // Restart from ERR clears error and completes
        a_en = 1'b1;
        run_watch(1'b1, 60, -1, -1, -1, -1, 1'b1);
        check("rs_err_before", err_h[0], 1);
        check("rs_err_cleared", err_h[1], 0);
        check("rs_no_err", err_at, -1);
        check_run("rs", 5, 4);
        check("rs_y", a_y_all(16'h0104), 1);

        // T=8: enc_done lands on the timeout cycle; start pulses mid-run
        a_lat = 8;
        set_a_x(16'h0200);
        run_watch(1'b1, 80, 12, 22, -1, 30, 1'b1);
        check("co_no_err", err_at, -1);
        check_run("co", 8, 4);
        check("co_y_mid", snap_y, 16'h0104);
        check("co_y", a_y_all(16'h0204), 1);

        // Abort in layer-1 WAIT (issue at 7, abort at 9, IDLE at 10)
        a_lat = 5;
        set_a_x(16'h0300);
        run_watch(1'b1, 30, -1, -1, 9, -1, 1'b1);
        check("ab_no_done", done_at, -1);
        check("ab_busy_before", busy_h[9], 1);
        check("ab_layer_before", layer_h[9], 1);
        check("ab_busy_after", busy_h[10], 0);
        check("ab_layer_after", layer_h[10], 0);
        check("ab_nstart", st_cyc.size(), 2);
        check("ab_y_held", a_y_all(16'h0204), 1);

        set_a_x(16'h0400);
        run_watch(1'b1, 60, -1, -1, -1, -1, 1'b1);
        check_run("ab2", 5, 4);
        check("ab2_y", a_y_all(16'h0404), 1);

        // Reset during layer-2 WAIT (issue at 13, reset at 15)
        set_a_x(16'h0500);
        run_watch(1'b1, 15, -1, -1, -1, -1, 1'b0);
        check("rw_layer_before", layer_h[15], 2);
        check("rw_busy_before", busy_h[15], 1);
        rst_n = 1'b0;
        #1;
        check("rw_busy", a_busy, 0);
        check("rw_layer", a_layer, 0);
        check("rw_y_zero", a_y_all(16'h0000), 1);
        check("rw_encx_zero", a_x_all(16'h0000), 1);
        @(negedge clk);
        check("rw_enc_start", a_enc_start, 0);
        check("rw_done", a_done, 0);
        check("rw_error", a_error, 0);
        rst_n = 1'b1;
        run_watch(1'b0, 8, -1, -1, -1, -1, 1'b0);
        busy_sum = 0;
        for (int t = 0; t <= 8; t++) busy_sum += int'(busy_h[t]);
        check("rw_post_busy", busy_sum, 0);
        check("rw_post_done", done_cnt, 0);
        check("rw_post_nstart", st_cyc.size(), 0);
        check("rw_post_y", a_y_all(16'h0000), 1);

        // Single-layer instance, T=3: issue at 1, done at 5, y = x + 1
        sel = 1'b1;
        @(negedge clk);
        run_watch(1'b1, 20, -1, -1, -1, -1, 1'b1);
        check_run("one", 3, 1);
        for (int i = 0; i < BN; i++)
            check($sformatf("one_y%0d", i), b_y_out[i], 16'h0101 + 16'(i * 3));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
